// File: rtl/countdown_timer_32bit.sv
// Countdown timer with load/start strobes, pause via enable and a one-cycle underflow pulse.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN for periodic mode; the default build is one-shot.
module countdown_timer_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_value;
    end
  end
`endif

  // busy/done are updated together with state so they stay pure registered decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      underflow <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (load) begin
        count <= load_value;
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
          RUN: begin
            if (enable) begin
              if (count != '0) begin
                count <= count - ONE;
              end else begin
                underflow <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                count <= reload;
`else
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_32bit.sv
// Directed bench for countdown_timer_32bit: each step queues its expected outputs,
// then pops and checks them one edge later. Covers both builds via COUNTDOWN_TIMER_AUTORELOAD_EN.
module tb_countdown_timer_32bit;

  localparam int W = 32;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic [W-1:0] count;
  logic         underflow;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [W-1:0] count;
    logic         uf;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failures  = 0;

  countdown_timer_32bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .count      (count),
    .underflow  (underflow),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string tag, input logic rs, input logic ld, input logic st,
                      input logic en, input logic [W-1:0] lv, input logic [W-1:0] ec,
                      input logic eu, input logic eb, input logic ed);
    exp_t e;
    reset      = rs;
    load       = ld;
    start      = st;
    enable     = en;
    load_value = lv;
    sb.push_back('{ec, eu, eb, ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    assert (count === e.count) else begin
      failures++;
      $error("FAIL %s count: got %0d expected %0d", tag, count, e.count);
    end
    tests_run++;
    assert (underflow === e.uf) else begin
      failures++;
      $error("FAIL %s underflow: got %b expected %b", tag, underflow, e.uf);
    end
    tests_run++;
    assert (busy === e.busy) else begin
      failures++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, e.busy);
    end
    tests_run++;
    assert (done === e.done) else begin
      failures++;
      $error("FAIL %s done: got %b expected %b", tag, done, e.done);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; enable = 1'b0; load_value = '0;

    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    // One-shot: load 3, run to terminal, then restart from DONE.
    step("os_load", 0, 1, 0, 0, 3, 3, 0, 0, 0);
    step("os_e0",   0, 0, 1, 1, 0, 3, 0, 1, 0);
    for (int k = 1; k <= 3; k++) step("os_run", 0, 0, 0, 1, 0, W'(3 - k), 0, 1, 0);
    step("os_term",    0, 0, 0, 1, 0, 0, 1, 0, 1);
    step("os_done",    0, 0, 0, 1, 0, 0, 0, 0, 1);
    step("os_restart", 0, 0, 1, 1, 0, 0, 0, 1, 0);
    step("os_reterm",  0, 0, 0, 1, 0, 0, 1, 0, 1);
`else
    // Periodic: load 2, count 2,1,0 repeating with pulses on reload edges.
    step("ar_load", 0, 1, 0, 0, 2, 2, 0, 0, 0);
    step("ar_e0",   0, 0, 1, 1, 0, 2, 0, 1, 0);
    for (int k = 1; k <= 8; k++)
      step("ar_run", 0, 0, 0, 1, 0, W'(2 - (k % 3)), (k % 3) == 0, 1, 0);
    step("ar_zload", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("ar_zstart", 0, 0, 1, 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) step("ar_zrun", 0, 0, 0, 1, 0, 0, 1, 1, 0);
    step("ar_zpause", 0, 0, 0, 0, 0, 0, 0, 1, 0);
`endif

    // Pause on edges 3..5 after start delays the terminal event by three cycles.
    step("p_load", 0, 1, 0, 0, 5, 5, 0, 0, 0);
    step("p_e0",   0, 0, 1, 1, 0, 5, 0, 1, 0);
    step("p_e1",   0, 0, 0, 1, 0, 4, 0, 1, 0);
    step("p_e2",   0, 0, 0, 1, 0, 3, 0, 1, 0);
    for (int k = 0; k < 3; k++) step("p_hold", 0, 0, 0, 0, 0, 3, 0, 1, 0);
    step("p_e6",   0, 0, 0, 1, 0, 2, 0, 1, 0);
    step("p_e7",   0, 0, 0, 1, 0, 1, 0, 1, 0);
    step("p_e8",   0, 0, 0, 1, 0, 0, 0, 1, 0);
    step("p_term", 0, 0, 0, 1, 0, AUTO ? W'(5) : W'(0), 1, AUTO, !AUTO);

    // Load wins over start; enable is ignored in IDLE; start is ignored in RUN.
    step("ls_both",   0, 1, 1, 1, 7, 7, 0, 0, 0);
    step("ls_idle",   0, 0, 0, 1, 0, 7, 0, 0, 0);
    step("ls_start",  0, 0, 1, 1, 0, 7, 0, 1, 0);
    step("ls_run",    0, 0, 0, 1, 0, 6, 0, 1, 0);
    step("ls_rstart", 0, 0, 1, 1, 0, 5, 0, 1, 0);
    step("ls_pause",  0, 0, 1, 0, 0, 5, 0, 1, 0);

    // Reset mid-run at count 2 aborts without a pulse.
    step("rr_run4", 0, 0, 0, 1, 0, 4, 0, 1, 0);
    step("rr_run3", 0, 0, 0, 1, 0, 3, 0, 1, 0);
    step("rr_run2", 0, 0, 0, 1, 0, 2, 0, 1, 0);
    step("rr_reset", 1, 1, 1, 1, 9, 0, 0, 0, 0);
    step("rr_after", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("rr_after", 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Load during RUN returns to IDLE with the new value.
    step("lr_load",  0, 1, 0, 0, 9, 9, 0, 0, 0);
    step("lr_start", 0, 0, 1, 1, 0, 9, 0, 1, 0);
    step("lr_run",   0, 0, 0, 1, 0, 8, 0, 1, 0);
    step("lr_reld",  0, 1, 0, 1, 2, 2, 0, 0, 0);
    step("lr_idle",  0, 0, 0, 1, 0, 2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer_32bit.md
COUNTDOWN_TIMER_32BIT -- requirements
Module: countdown_timer_32bit

Interface
REQ-001 Parameter: WIDTH, default 32, counter and load-value width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  active-high count enable; low = hold/pause.
REQ-005 load  input  1  single-cycle load strobe.
REQ-006 load_value  input  WIDTH  value captured on load.
REQ-007 start  input  1  single-cycle start strobe.
REQ-008 count  output  WIDTH  current counter value, registered.
REQ-009 underflow  output  1  registered one-cycle pulse when a terminal count is consumed.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 A load SHALL apply in any state: count <= load_value, reload register <= load_value, state -> IDLE, underflow <= 0.
REQ-014 Load SHALL take priority over start when both are asserted in the same cycle.
REQ-015 Start SHALL act only in IDLE or DONE: state -> RUN, count unchanged on that edge.
REQ-016 Start SHALL be ignored while in RUN.
REQ-017 In RUN with enable=1 and count != 0: count <= count - 1, underflow <= 0.
REQ-018 In RUN with enable=1 and count == 0: underflow <= 1 for exactly one cycle, with terminal action per REQ-026/REQ-027.
REQ-019 In RUN with enable=0: count held, underflow <= 0, state unchanged.
REQ-020 Count SHALL never wrap from 0 to all-ones; the modulo arithmetic is WIDTH-bit unsigned.
REQ-021 Latency: with value N loaded, start sampled at edge e0 and enable held high, count SHALL equal N-k after edge e0+k (k <= N), and underflow SHALL be high after edge e0+N+1 only.
REQ-022 busy = (state == RUN) and done = (state == DONE), both registered state decodes with no combinational path from inputs.
REQ-023 In IDLE and DONE, count SHALL hold and enable SHALL have no effect.

Reset
REQ-024 reset SHALL be sampled on the rising clk edge only and SHALL take priority over load, start and enable.
REQ-025 On reset: count = 0, reload register = 0, underflow = 0, busy = 0, done = 0, state = IDLE; a reset asserted mid-RUN SHALL abort the countdown with no underflow pulse.

Configuration
REQ-026 With macro COUNTDOWN_TIMER_AUTORELOAD_EN defined, the terminal event in RUN SHALL set count <= reload register and keep state RUN (periodic mode); a reload value of 0 SHALL then pulse underflow on every enabled cycle.
REQ-027 Without COUNTDOWN_TIMER_AUTORELOAD_EN, the terminal event SHALL keep count = 0 and move state to DONE (one-shot mode); a new start from DONE SHALL re-enter RUN and pulse underflow on the next enabled cycle.

Verification
REQ-028 Reset then idle 5 cycles -> count = 0, underflow = 0, busy = 0, done = 0 throughout.
REQ-029 Load 3, start, enable=1, one-shot build -> count 3,2,1,0 after edges 0..3; underflow high only after edge 4; done = 1 and busy = 0 from edge 4.
REQ-030 Load 5, start, enable low for cycles 2-4 -> count holds at 3 during the pause, resumes decrementing after, and underflow is delayed by exactly 3 cycles.
REQ-031 Same-cycle load=1 with load_value 7 and start=1 -> state IDLE, count = 7, busy = 0; a subsequent start alone enters RUN.
REQ-032 Reset asserted in RUN with count = 2 -> next edge count = 0, state IDLE, no underflow pulse.
REQ-033 Autoreload build: load 2, start, enable held 9 cycles -> count sequence 2,1,0,2,1,0,2,1,0 with underflow pulses after edges 3 and 6, busy held high.
